dmem_resp: RTL and testbench
============================

Name: dmem_resp

Overview:
- Multi-cycle data-memory responder. It is the far end of the address path that the execute-stage address adder drives for LW/SW.
- Accepts one load/store request at a time on a valid/ready handshake, models a fixed access latency, and returns read data plus a completion pulse.
- The pipeline stalls on !req_ready / awaits rsp_valid.
- Memory is an internal word array of 16-bit words addressed by byte address.

Parameters:
- AW, 10, word-index width; depth = 2**AW words (byte range 0 .. 2**(AW+1)-1).
- LATENCY, 4, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept this cycle.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  16  byte address; bit 0 ignored (always word-aligned).
- req_wdata  in  16  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  load data, valid with rsp_valid; 0 for stores and errors.
- rsp_err  out  1  with rsp_valid: address out of range.
- busy  out  1  request accepted and not yet responded.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, counter=0, latched request regs=0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Memory array is not cleared.
- Accept: req_valid && req_ready at a rising edge latches we/addr/wdata.
- Address decode:
  - index = addr[AW:1].
  - out_of_range = (addr[15:AW+1] != 0).
- States:
  - IDLE: req_ready=1, busy=0. On accept: if LATENCY==1 go RESP, else go WAIT with counter=LATENCY-2.
  - WAIT: req_ready=0, busy=1. Counter decrements each cycle; at 0 go RESP.
  - RESP: rsp_valid=1, busy=0, req_ready=1.
    - Load in range: rsp_rdata = mem[index].
    - Store in range: mem[index] <= wdata at the edge ending RESP; rsp_rdata=0.
    - Out of range: rsp_err=1, rsp_rdata=0, no write.
    - Exit: a new accept in RESP goes WAIT/RESP as from IDLE (back-to-back); otherwise go IDLE.
- Latency: rsp_valid is high exactly LATENCY cycles after the accept cycle. Back-to-back throughput is one request per LATENCY cycles.
- Read data is taken from the array in RESP. A load accepted in the RESP cycle of a store to the same word returns the new data.
- req_valid while req_ready=0 is ignored. The requester must hold the request until accepted; no requirement on inputs in other cycles.
- Reset mid-operation aborts the request. No write commits, and no rsp_valid is produced for it.
- rsp_valid, rsp_rdata and rsp_err are registered-state-decoded with no combinational path from req_*.

Optional Feature:
- DMEM_LASTHIT_EN
- Defined: adds one tag register (valid, index, data), updated on every in-range RESP; cleared by reset.
  - A load accepted in IDLE/RESP whose index matches a valid tag bypasses WAIT and goes straight to RESP. It returns the tag data (latency 1).
  - Stores and misses use the full LATENCY.
- Undefined: no tag register; every access takes LATENCY cycles.

Test Plan:
- Reset, then SW addr=0x0010 wdata=0xBEEF (LATENCY=4) -> req_ready low 3 cycles, rsp_valid 1 cycle at accept+4, rsp_rdata=0, rsp_err=0; then LW 0x0011 -> rsp_rdata=0xBEEF at accept+4 (bit 0 ignored).
- Back-to-back: SW 0x0020=0x1234 with LW 0x0020 held on req_valid -> LW accepted in the SW RESP cycle, returns 0x1234 four cycles later; no idle cycle between.
- Out of range (AW=10): LW 0x0800 -> rsp_valid with rsp_err=1, rsp_rdata=0; SW 0x0800=0xFFFF, then LW 0x0000 -> 0x0000 error store did not alias.
- Reset mid-op: SW 0x0030=0xAAAA accepted, rst_n low 2 cycles later -> no rsp_valid, req_ready=1 after release, LW 0x0030 returns prior contents (not 0xAAAA).
- LATENCY=1 build: LW/SW pairs -> rsp_valid the cycle after each accept, continuous one-per-cycle throughput.
- DMEM_LASTHIT_EN: LW 0x0040 (miss, latency 4), repeat LW 0x0040 -> rsp_valid at accept+1 with same data; intervening SW 0x0040=0x5555 then LW -> hit returns 0x5555. Without the macro, all take 4 cycles.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp -- multi-cycle data-memory responder for LW/SW.
//
// Accepts one request at a time on a valid/ready handshake and answers
// with a one-cycle rsp_valid pulse exactly LATENCY cycles after the
// accept cycle. The storage is an internal array of 16-bit words that is
// addressed by byte address. Bit 0 of the address is ignored. Any
// address with bits above AW set is out of range: it reports rsp_err,
// returns zero and never writes the array.
//
// Parameters:
//   AW       word-index width, depth = 2**AW words
//   LATENCY  accept-to-response cycles, 1..15
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept this cycle
//   req_we     1 = store, 0 = load
//   req_addr   byte address (bit 0 ignored)
//   req_wdata  store data
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  load data with rsp_valid; 0 for stores and errors
//   rsp_err    with rsp_valid: address out of range
//   busy       request accepted and not yet responded
//
// Optional feature (macro DMEM_LASTHIT_EN): a single last-hit tag
// (valid, index, data) is refreshed on every in-range response. An
// in-range load whose index matches the valid tag skips the wait state
// and responds on the next cycle with the tag data.
module dmem_resp #(
  parameter int AW      = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter starts at LATENCY-2: the accept cycle and the RESP cycle
  // are not counted by the WAIT state.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nx;

  logic            req_oor;
  logic [AW-1:0]   req_idx;
  logic            req_hit;
  logic            accept;

  logic            we_p1;
  logic            oor_p1;
  logic [AW-1:0]   idx_p1;
  logic [15:0]     wdata_p1;

  logic [15:0]     mem [0:(2**AW)-1];
  logic [15:0]     rd_word;
  logic            commit_wr;
  logic            unused_addr_bit;

  assign unused_addr_bit = req_addr[0];

  // Request decode
  assign req_idx = req_addr[AW:1];
  assign req_oor = (req_addr >> (AW + 1)) != 16'd0;
  assign accept  = req_valid && req_ready;

`ifdef DMEM_LASTHIT_EN
  logic            tag_vld;
  logic [AW-1:0]   tag_idx;
  logic [15:0]     tag_data;
  logic            hit_p1;

  // The hit check uses the tag as it stands in the accept cycle. A store
  // to the same word finishing in that cycle refreshes the tag at the same
  // edge, so a hit RESP always reads the tag after that refresh.
  assign req_hit = !req_we && !req_oor && tag_vld && (tag_idx == req_idx);
  assign rd_word = hit_p1 ? tag_data : mem[idx_p1];
`else
  assign req_hit = 1'b0;
  assign rd_word = mem[idx_p1];
`endif

  // Control state, counter and latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_p1    <= 1'b0;
      oor_p1   <= 1'b0;
      idx_p1   <= '0;
      wdata_p1 <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_p1    <= req_we;
        oor_p1   <= req_oor;
        idx_p1   <= req_idx;
        wdata_p1 <= req_wdata;
      end
    end
  end

`ifdef DMEM_LASTHIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p1   <= 1'b0;
      tag_vld  <= 1'b0;
      tag_idx  <= '0;
      tag_data <= 16'd0;
    end else begin
      if (accept) begin
        hit_p1 <= req_hit;
      end
      if (state == RESP && !oor_p1) begin
        tag_vld  <= 1'b1;
        tag_idx  <= idx_p1;
        tag_data <= we_p1 ? wdata_p1 : rd_word;
      end
    end
  end
`endif

  // Next-state and handshake decode. The outputs depend only on state.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_ready = 1'b1;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE, RESP: begin
        rsp_valid = (state == RESP);
        if (accept) begin
          if (LATENCY == 1 || req_hit) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        req_ready = 1'b0;
        busy      = 1'b1;
        if (cnt == 4'd0) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Response data: taken from the array (or the tag) during RESP only
  always_comb begin
    rsp_rdata = 16'd0;
    rsp_err   = 1'b0;
    if (state == RESP) begin
      if (oor_p1) begin
        rsp_err = 1'b1;
      end else if (!we_p1) begin
        rsp_rdata = rd_word;
      end
    end
  end

  // A store commits at the edge that ends RESP. A reset during RESP
  // forces the state to IDLE first, so an aborted store never writes.
  assign commit_wr = (state == RESP) && we_p1 && !oor_p1;

  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem[idx_p1] <= wdata_p1;
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
`timescale 1ns/1ps
module tb_dmem_resp;

  localparam int AW   = 10;
  localparam int LAT  = 4;
  localparam int NW   = 2**AW;
`ifdef DMEM_LASTHIT_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = LAT;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_resp #(.AW(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural model: one outstanding request with a due cycle, a word
  // array of what has been stored, and the last in-range word touched.
  logic [15:0] m_mem [0:NW-1];
  bit          known [0:NW-1];
  bit          pend = 1'b0;
  int          p_due;
  bit          p_we;
  bit          p_oor;
  int          p_idx;
  logic [15:0] p_wd;
  bit          tag_v = 1'b0;
  int          tag_idx;

  initial begin
    bit ev, eb, hit, noor;
    int nidx;
    for (int i = 0; i < NW; i++) known[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend  = 1'b0;
        tag_v = 1'b0;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
      end else begin
        ev = pend && (p_due == cyc);
        eb = pend && (p_due > cyc);
        chk("req_ready", req_ready, !eb);
        chk("busy", busy, eb);
        chk("rsp_valid", rsp_valid, ev);
        noor = (req_addr >= 16'(2**(AW+1)));
        nidx = (int'(req_addr) % (2**(AW+1))) / 2;
        hit  = 1'b0;
`ifdef DMEM_LASTHIT_EN
        hit = !req_we && !noor && tag_v && (tag_idx == nidx);
`endif
        if (ev) begin
          chk("rsp_err", rsp_err, p_oor);
          if (p_oor || p_we) begin
            chk("rsp_rdata_zero", rsp_rdata, 0);
          end else if (known[p_idx]) begin
            chk("rsp_rdata_load", rsp_rdata, m_mem[p_idx]);
          end
          if (!p_oor) begin
            if (p_we) begin
              m_mem[p_idx] = p_wd;
              known[p_idx] = 1'b1;
            end
            tag_v   = 1'b1;
            tag_idx = p_idx;
          end
          pend = 1'b0;
        end
        if (req_valid && !eb) begin
          pend  = 1'b1;
          p_due = cyc + (hit ? 1 : LAT);
          p_we  = req_we;
          p_oor = noor;
          p_idx = nidx;
          p_wd  = req_wdata;
        end
      end
    end
  end

  // Drive a request and hold it until accepted; returns the accept cycle.
  task automatic issue(input bit we, input logic [15:0] a, input logic [15:0] d,
                       output int acc, output bit rv_at_acc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    acc       = -1;
    rv_at_acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready && rst_n) begin
        acc       = cyc;
        rv_at_acc = rsp_valid;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=no accept required=accept within 50 cycles");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic wait_rsp(input int acc, output logic [15:0] rd, output bit err,
                          output int lat, output int nrl);
    lat = -1;
    nrl = 0;
    rd  = 16'd0;
    err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - acc;
        rd  = rsp_rdata;
        err = rsp_err;
        break;
      end
      if (!req_ready) nrl++;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: actual=no rsp_valid required=rsp_valid within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input bit we, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output bit err, output int lat, output int nrl);
    int acc;
    bit rv;
    issue(we, a, d, acc, rv);
    wait_rsp(acc, rd, err, lat, nrl);
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] a;
    bit          err, rv, rv2;
    int          lat, nrl, a1, a2;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      xact(1'b1, 16'(i * 2), 16'(i * 16'h0101), rd, err, lat, nrl);
    end

    xact(1'b1, 16'h0010, 16'hBEEF, rd, err, lat, nrl);
    chk("sw_latency", lat, 4);
    chk("sw_ready_low_cycles", nrl, 3);
    chk("sw_rdata", rd, 16'h0000);
    chk("sw_err", err, 0);
    xact(1'b0, 16'h0011, 16'h0000, rd, err, lat, nrl);
    chk("lw_odd_byte_data", rd, 16'hBEEF);
    chk("lw_odd_byte_latency", lat, HIT_LAT);

    issue(1'b1, 16'h0020, 16'h1234, a1, rv);
    issue(1'b0, 16'h0020, 16'h0000, a2, rv2);
    chk("b2b_accept_gap", a2 - a1, 4);
    chk("b2b_accept_in_resp", rv2, 1);
    wait_rsp(a2, rd, err, lat, nrl);
    chk("b2b_lw_data", rd, 16'h1234);
    chk("b2b_lw_latency", lat, 4);

    xact(1'b0, 16'h0800, 16'h0000, rd, err, lat, nrl);
    chk("oor_lw_err", err, 1);
    chk("oor_lw_rdata", rd, 16'h0000);
    xact(1'b1, 16'h0800, 16'hFFFF, rd, err, lat, nrl);
    chk("oor_sw_err", err, 1);
    xact(1'b0, 16'h0000, 16'h0000, rd, err, lat, nrl);
    chk("oor_no_alias", rd, 16'h0000);
    chk("oor_no_alias_err", err, 0);

    issue(1'b1, 16'h0030, 16'hAAAA, a1, rv);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after_release", req_ready, 1);
    chk("abort_no_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    xact(1'b0, 16'h0030, 16'h0000, rd, err, lat, nrl);
    chk("abort_prior_contents", rd, 16'h1818);
    chk("abort_lw_latency", lat, 4);

    xact(1'b0, 16'h0040, 16'h0000, rd, err, lat, nrl);
    chk("tag_first_lw_data", rd, 16'h2020);
    chk("tag_first_lw_latency", lat, 4);
    xact(1'b0, 16'h0040, 16'h0000, rd, err, lat, nrl);
    chk("tag_repeat_lw_data", rd, 16'h2020);
    chk("tag_repeat_lw_latency", lat, HIT_LAT);
    xact(1'b1, 16'h0040, 16'h5555, rd, err, lat, nrl);
    chk("tag_sw_latency", lat, 4);
    xact(1'b0, 16'h0040, 16'h0000, rd, err, lat, nrl);
    chk("tag_after_sw_data", rd, 16'h5555);
    chk("tag_after_sw_latency", lat, HIT_LAT);

    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = int'($urandom_range(0, 7));
      if (kind == 0) a = 16'h0800 | 16'($urandom);
      else           a = 16'($urandom_range(0, 127));
      issue(1'($urandom), a, 16'($urandom), a1, rv);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (LAT + 4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
